// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake state, word type and the arbiter FSM state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arbstate_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Cache-side and RAM-side bus of the RAM arbiter; master = caches + RAM model, slave = arbiter.
interface ram_arbiter_if
    import cpu_types_pkg::*;
#(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    wen;
    logic [NREQ*32-1:0] addr;
    logic [NREQ*32-1:0] store;
    ramstate_t          ramstate;
    word_t              ramload;
    logic               ramREN;
    logic               ramWEN;
    word_t              ramaddr;
    word_t              ramstore;
    logic [NREQ-1:0]    rwait;
    word_t              rload;
    logic [NREQ-1:0]    grant;
    logic               timeout_err;

    modport master (
        output req, wen, addr, store, ramstate, ramload,
        input  ramREN, ramWEN, ramaddr, ramstore, rwait, rload, grant, timeout_err
    );

    modport slave (
        input  req, wen, addr, store, ramstate, ramload,
        output ramREN, ramWEN, ramaddr, ramstore, rwait, rload, grant, timeout_err
    );
endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first set mask bit at or after ptr, wrapping NREQ-1 -> 0.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] mask,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] winner,
    output logic            valid
);
    int idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!valid && mask[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin, transaction-locking arbiter sharing one RAM port among NREQ cache requesters.
// Optional WRITE_PRIORITY_EN: pending writes win arbitration over reads (still round-robin).
//
// state | meaning
// IDLE  | no owner; pick next winner from ptr if any req
// ISSUE | owner drives RAM until ACCESS, req drop, or watchdog abort
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input logic          CLK,
    input logic          RST,
    ram_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = 10;

    arbstate_t       state, state_nxt;
    logic [NREQ-1:0] grant_q, grant_nxt;
    logic [PW-1:0]   ptr_q, ptr_nxt;
    logic [WW-1:0]   wdog_q, wdog_nxt;
    logic            terr_q, terr_nxt;
    logic [NREQ-1:0] pick;
    logic            pick_vld;
    logic [PW-1:0]   own, own_inc;
    logic            access, wdog_exp;

`ifdef WRITE_PRIORITY_EN
    logic [NREQ-1:0] pick_w, pick_a;
    logic            vld_w, vld_a;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick_w (
        .mask(bus.req & bus.wen), .ptr(ptr_q), .winner(pick_w), .valid(vld_w)
    );
    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick_a (
        .mask(bus.req), .ptr(ptr_q), .winner(pick_a), .valid(vld_a)
    );

    assign pick     = vld_w ? pick_w : pick_a;
    assign pick_vld = vld_w | vld_a;
`else
    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .mask(bus.req), .ptr(ptr_q), .winner(pick), .valid(pick_vld)
    );
`endif

    always_comb begin
        own = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant_q[i]) own = PW'(i);
    end

    // Explicit wrap so non-power-of-two NREQ never lands on an unused index.
    assign own_inc  = (own == PW'(NREQ - 1)) ? '0 : own + 1'b1;
    assign access   = (bus.ramstate == ACCESS);
    assign wdog_exp = (wdog_q == WW'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            wdog_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            ptr_q   <= ptr_nxt;
            wdog_q  <= wdog_nxt;
            terr_q  <= terr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        ptr_nxt   = ptr_q;
        wdog_nxt  = wdog_q;
        terr_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant_nxt = pick;
                    wdog_nxt  = '0;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // ACCESS wins over the watchdog in the same cycle.
                if (access || !bus.req[own] || wdog_exp) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = own_inc;
                    wdog_nxt  = '0;
                    terr_nxt  = !access && bus.req[own] && wdog_exp;
                end else begin
                    wdog_nxt = wdog_q + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.rwait    = '1;
        if (!RST && state == ISSUE) begin
            bus.ramREN   = ~bus.wen[own];
            bus.ramWEN   = bus.wen[own];
            bus.ramaddr  = bus.addr[int'(own)*32 +: 32];
            bus.ramstore = bus.store[int'(own)*32 +: 32];
            if (access) bus.rwait[own] = 1'b0;
        end
    end

    assign bus.rload       = bus.ramload;
    assign bus.grant       = grant_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table plus hand sequences for abort, watchdog and reset.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 4;

    typedef struct {
        logic [3:0] req;
        logic [3:0] wen;
        int         acc_at;
        logic [3:0] exp_grant;
    } vec_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    ram_arbiter_if #(.NREQ(NREQ)) bus ();

    ram_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] exp_q[$];
    int         done_cnt[NREQ];
    vec_t       vt[16];

    function automatic word_t addr_of(int i);
        return word_t'(32'h100 + 32'h40 * i);
    endfunction

    function automatic word_t store_of(int i);
        return word_t'(32'hD000_0000 + i);
    endfunction

    function automatic int idx_of(logic [3:0] g);
        int r = 0;
        for (int i = 0; i < NREQ; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Completion monitor: any rwait pulse must match the next expected owner.
    always @(negedge CLK) begin
        logic [3:0] act, e;
        if (RST === 1'b0 && bus.rwait !== 4'hF) begin
            act = ~bus.rwait;
            if (exp_q.size() == 0) begin
                chk("unexpected rwait pulse", 32'(act), 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("rwait owner", 32'(act), 32'(e));
                for (int i = 0; i < NREQ; i++) if (e[i]) done_cnt[i]++;
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int   o;
        logic exp_ren;
        bus.req      = v.req;
        bus.wen      = v.wen;
        bus.ramstate = FREE;
        #1;
        chk("idle grant", 32'(bus.grant), 32'h0);
        chk("idle timeout_err", 32'(bus.timeout_err), 32'h0);
        step();
        for (int k = 0; k < 4 && bus.grant == 4'h0; k++) step();
        chk("grant", 32'(bus.grant), 32'(v.exp_grant));
        if (bus.grant == 4'h0) return;
        o       = idx_of(v.exp_grant);
        exp_ren = v.wen[o] ? 1'b0 : 1'b1;
        exp_q.push_back(v.exp_grant);
        for (int c = 1; c <= v.acc_at; c++) begin
            bus.ramstate = (c == v.acc_at) ? ACCESS : BUSY;
            bus.ramload  = $urandom;
            #1;
            chk("ramREN", 32'(bus.ramREN), 32'(exp_ren));
            chk("ramWEN", 32'(bus.ramWEN), 32'(v.wen[o]));
            chk("ramaddr", bus.ramaddr, addr_of(o));
            chk("ramstore", bus.ramstore, store_of(o));
            chk("rload", bus.rload, bus.ramload);
            chk("grant held", 32'(bus.grant), 32'(v.exp_grant));
            step();
        end
        bus.ramstate = FREE;
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vt[0]  = '{4'b0001, 4'b0000, 3, 4'b0001};
        vt[1]  = '{4'b1111, 4'b0000, 2, 4'b0010};
        vt[2]  = '{4'b1111, 4'b0000, 2, 4'b0100};
        vt[3]  = '{4'b1111, 4'b0000, 2, 4'b1000};
        vt[4]  = '{4'b1111, 4'b0000, 2, 4'b0001};
        vt[5]  = '{4'b1111, 4'b0000, 2, 4'b0010};
        vt[6]  = '{4'b1111, 4'b0000, 2, 4'b0100};
        vt[7]  = '{4'b1111, 4'b0000, 2, 4'b1000};
        vt[8]  = '{4'b1111, 4'b0000, 2, 4'b0001};
        vt[9]  = '{4'b0100, 4'b0100, 1, 4'b0100};
        vt[10] = '{4'b1001, 4'b1000, 2, 4'b1000};
        vt[11] = '{4'b1001, 4'b0001, 4, 4'b0001};
        vt[12] = '{4'b0011, 4'b0000, 1, 4'b0010};
        vt[13] = '{4'b1000, 4'b0000, 1, 4'b1000};
`ifdef WRITE_PRIORITY_EN
        vt[14] = '{4'b0011, 4'b0010, 2, 4'b0010};
        vt[15] = '{4'b0011, 4'b0000, 2, 4'b0001};
`else
        vt[14] = '{4'b0011, 4'b0010, 2, 4'b0001};
        vt[15] = '{4'b0011, 4'b0000, 2, 4'b0010};
`endif
        for (int i = 0; i < NREQ; i++) begin
            done_cnt[i]           = 0;
            bus.addr[32*i +: 32]  = addr_of(i);
            bus.store[32*i +: 32] = store_of(i);
        end

        RST          = 1'b1;
        bus.req      = 4'hF;
        bus.wen      = 4'h0;
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h0;
        step();
        step();
        chk("rst grant", 32'(bus.grant), 32'h0);
        chk("rst ramREN", 32'(bus.ramREN), 32'h0);
        chk("rst ramWEN", 32'(bus.ramWEN), 32'h0);
        chk("rst ramaddr", bus.ramaddr, 32'h0);
        chk("rst ramstore", bus.ramstore, 32'h0);
        chk("rst rwait", 32'(bus.rwait), 32'hF);
        chk("rst timeout_err", 32'(bus.timeout_err), 32'h0);
        RST          = 1'b0;
        bus.req      = 4'h0;
        bus.ramstate = FREE;
        step();

        for (int i = 0; i < 16; i++) begin
            run_vec(vt[i]);
            if (i == 8) begin
                chk("fair cnt0", 32'(done_cnt[0]), 32'd3);
                chk("fair cnt1", 32'(done_cnt[1]), 32'd2);
                chk("fair cnt2", 32'(done_cnt[2]), 32'd2);
                chk("fair cnt3", 32'(done_cnt[3]), 32'd2);
            end
        end

        // Owner 2 drops req mid-ISSUE: no pulse, ptr moves to 3.
        bus.req = 4'b0100;
        bus.wen = 4'b0000;
        step();
        chk("abort grant", 32'(bus.grant), 32'b0100);
        bus.ramstate = BUSY;
        step();
        bus.req = 4'b0000;
        #1;
        chk("abort rwait", 32'(bus.rwait), 32'hF);
        step();
        chk("abort idle", 32'(bus.grant), 32'h0);
        bus.req = 4'b1111;
        step();
        chk("abort ptr3", 32'(bus.grant), 32'b1000);
        exp_q.push_back(4'b1000);
        bus.ramstate = ACCESS;
        step();
        bus.ramstate = FREE;

        // Watchdog abort, then a completion in the TIMEOUT cycle.
        bus.req = 4'b0011;
        step();
        chk("wdog grant", 32'(bus.grant), 32'b0001);
        bus.ramstate = BUSY;
        for (int c = 1; c <= TIMEOUT; c++) begin
            #1;
            chk("wdog no err", 32'(bus.timeout_err), 32'h0);
            chk("wdog held", 32'(bus.grant), 32'b0001);
            step();
        end
        chk("wdog err pulse", 32'(bus.timeout_err), 32'h1);
        chk("wdog idle", 32'(bus.grant), 32'h0);
        step();
        chk("wdog err clear", 32'(bus.timeout_err), 32'h0);
        chk("wdog next", 32'(bus.grant), 32'b0010);
        for (int c = 1; c <= TIMEOUT; c++) begin
            bus.ramstate = (c == TIMEOUT) ? ACCESS : BUSY;
            if (c == TIMEOUT) exp_q.push_back(4'b0010);
            step();
        end
        bus.ramstate = FREE;
        bus.req      = 4'b0000;
        #1;
        chk("edge no err", 32'(bus.timeout_err), 32'h0);
        chk("edge idle", 32'(bus.grant), 32'h0);

        // Reset mid-ISSUE drops the write and clears ptr.
        bus.req = 4'b0100;
        bus.wen = 4'b0100;
        step();
        chk("rstmid grant", 32'(bus.grant), 32'b0100);
        chk("rstmid ramWEN", 32'(bus.ramWEN), 32'h1);
        bus.ramstate = BUSY;
        step();
        RST = 1'b1;
        #1;
        chk("rstmid gated WEN", 32'(bus.ramWEN), 32'h0);
        chk("rstmid gated rwait", 32'(bus.rwait), 32'hF);
        step();
        RST          = 1'b0;
        bus.req      = 4'b0110;
        bus.wen      = 4'b0000;
        bus.ramstate = FREE;
        #1;
        chk("rstmid post grant", 32'(bus.grant), 32'h0);
        chk("rstmid post WEN", 32'(bus.ramWEN), 32'h0);
        chk("rstmid post REN", 32'(bus.ramREN), 32'h0);
        step();
        chk("rstmid ptr0", 32'(bus.grant), 32'b0010);
        exp_q.push_back(4'b0010);
        bus.ramstate = ACCESS;
        step();
        bus.ramstate = FREE;
        bus.req      = 4'b0000;
        step();
        step();
        chk("scoreboard empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Round-robin, transaction-locking arbiter sharing the single-ported RAM among NREQ cache requesters.
- Default NREQ=4: cpu0 icache, cpu0 dcache, cpu1 icache, cpu1 dcache.
- Sits between the cache controllers and the RAM model, replacing fixed-priority selection so that no requester starves.
- Holds a grant from issue until the RAM reports ACCESS, then rotates priority; a watchdog aborts hung transactions.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 255, maximum cycles in ISSUE before forced abort (1..1023).

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester access request (level).
- wen  in  NREQ  per-requester write enable; 0 = read.
- addr  in  NREQ*32  packed word addresses; requester i at [32i+31:32i].
- store  in  NREQ*32  packed write data, same packing.
- ramstate  in  2  ramstate_t from cpu_types_pkg (FREE, BUSY, ACCESS, ERROR).
- ramload  in  32  RAM read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- rwait  out  NREQ  per-requester wait; 0 only in the completing cycle.
- rload  out  32  ramload forwarded unchanged to all requesters.
- grant  out  NREQ  one-hot current owner, all zero when idle.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (RST high at an edge): state=IDLE, grant=0, ptr=0, wdog=0, timeout_err=0.
  - Outputs during reset: ramREN=ramWEN=0, ramaddr=ramstore=0, rwait=all 1.
  - RST mid-transaction drops the RAM request on the next edge; the RAM sees a dropped request, no data.
- State IDLE: if any req, select the winner by round-robin search starting at index ptr, wrapping NREQ-1 -> 0.
  - Register the winner into grant; go to ISSUE on the next edge.
  - Request in cycle N -> RAM strobes driven from cycle N+1.
- State ISSUE: drive RAM from the owner o.
  - ramREN = ~wen[o], ramWEN = wen[o], ramaddr = addr[o], ramstore = store[o].
  - All rwait = 1 except as below.
- ISSUE, ramstate==ACCESS: rwait[o]=0 combinationally in that cycle, then on the edge:
  - ptr = (o+1) mod NREQ, grant=0, wdog=0, state=IDLE.
  - Minimum 1 idle cycle between transactions.
- ISSUE, req[o] deasserted: abort to IDLE on the edge; no rwait pulse; ptr still advances past o.
- ISSUE, ramstate==ERROR: treated as BUSY; remain in ISSUE, request held.
- Watchdog:
  - wdog increments each ISSUE cycle without ACCESS.
  - When wdog==TIMEOUT and still no ACCESS: timeout_err=1 for one cycle (registered), abort to IDLE, ptr advances past o, owner rwait stays 1.
  - ACCESS in the same cycle wdog reaches TIMEOUT completes normally; no error.
- Other rules:
  - wen or addr changes by the owner mid-ISSUE are passed through unregistered; the caches must hold them stable.
  - Only one grant bit is ever set; grant never changes within ISSUE.
  - ptr width = clog2(NREQ); wrap via explicit compare, not power-of-two truncation.

Optional Feature:
- WRITE_PRIORITY_EN defined:
  - In IDLE, if any requester has req&wen, only those are candidates, still round-robin from ptr.
  - Reads are considered only when no write is pending, so dirty writebacks finish before refills.
- Undefined: plain round-robin over all req regardless of wen.

Decomposition:
- cpu_types_pkg already provides ramstate_t and word_t.
- Add to cpu_types_pkg: arbstate_t enum {IDLE, ISSUE}.
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: candidate mask [NREQ], ptr.
  - Outputs: one-hot winner, valid.
  - Reused for write-only and all-request masks under WRITE_PRIORITY_EN.

Test Plan:
- Single read: req=0001, wen=0, addr0=0x100, ramstate ACCESS on the 3rd ISSUE cycle.
  - Expect ramREN=1 and ramaddr=0x100 from cycle 1.
  - rwait[0]=0 exactly in the ACCESS cycle; grant 0001 -> 0000; ptr=1.
- Fairness: req=1111 held, ACCESS every 2nd ISSUE cycle.
  - Grants in order 0001, 0010, 0100, 1000, 0001; each requester gets exactly 2 completions in 8 transactions.
- Wrap: ptr=3, req=1001.
  - Grant 1000 first, then 0001; ptr returns to 0 then 1.
- Abort and reset: owner 2 drops req mid-ISSUE -> IDLE next edge, no rwait pulse, ptr=3.
  - Separately, RST asserted mid-ISSUE -> ramWEN/ramREN=0 next cycle, grant=0.
- Watchdog: TIMEOUT=4, ramstate stuck BUSY.
  - timeout_err pulses once after 4 ISSUE cycles; next requester granted.
  - Repeat with ACCESS in the TIMEOUT cycle -> completion, no error.
- WRITE_PRIORITY_EN: req=0011, wen=0010, ptr=0.
  - Grant 0010 first, then 0001. Without the macro: 0001 then 0010.
